// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle ARM control FSM with decode, condition check and NZCV flags
// Optional MC_MEMREADY_EN adds a MemReady input that stalls FETCH, MEMREAD and MEMWRITE.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
`ifdef MC_MEMREADY_EN
  input  logic        MemReady,
`endif
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);

  logic [STATE_W-1:0] state_q, state_d;
  logic [3:0]         flags_q, flags_d;

  logic mem_rdy;
`ifdef MC_MEMREADY_EN
  assign mem_rdy = MemReady;
`else
  assign mem_rdy = 1'b1;
`endif

  // Instr holds IR[31:12]; field positions below are offset by 12.
  logic [3:0] cond;
  logic [1:0] op;
  logic       imm_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic       u_bit;
  logic       l_bit;
  logic       rd_pc;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign imm_bit   = Instr[13];
  assign cmd       = Instr[12:9];
  assign s_bit     = Instr[8];
  assign u_bit     = Instr[11];
  assign l_bit     = Instr[8];
  assign rd_pc     = (Instr[3:0] == 4'b1111);
  assign unused_rn = ^Instr[7:4];

  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  logic cond_ex;
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = !flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = !flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = !flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = !flag_v;
      4'b1000: cond_ex = flag_c && !flag_z;
      4'b1001: cond_ex = !flag_c || flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
      4'b1101: cond_ex = flag_z || (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Unknown cmd executes as ADD but never touches the flags.
  logic [1:0] alu_dp;
  logic [1:0] flag_w;
  logic       is_cmp;
  always_comb begin
    alu_dp = 2'b00;
    flag_w = 2'b00;
    is_cmp = 1'b0;
    case (cmd)
      4'b0100: begin alu_dp = 2'b00; flag_w = 2'b11; end
      4'b0010: begin alu_dp = 2'b01; flag_w = 2'b11; end
      4'b0000: begin alu_dp = 2'b10; flag_w = 2'b10; end
      4'b1100: begin alu_dp = 2'b11; flag_w = 2'b10; end
      4'b1010: begin alu_dp = 2'b01; flag_w = 2'b11; is_cmp = 1'b1; end
      default: begin alu_dp = 2'b00; flag_w = 2'b00; end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b00:   state_d = imm_bit ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = l_bit ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if ((state_q == S_EXECR || state_q == S_EXECI) && s_bit && cond_ex) begin
      if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
      if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  // Every output is forced low while reset is held, including the static decode.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = 2'b00;
    if (Rst) begin
      ImmSrc = op;
      RegSrc = {(op == 2'b01) && !l_bit, op == 2'b10};
      case (state_q)
        S_FETCH: begin
          IRWrite   = mem_rdy;
          PCWrite   = mem_rdy;
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        S_DECODE: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        S_MEMADR: begin
          ALUSrcB    = 2'b01;
          ALUControl = u_bit ? 2'b00 : 2'b01;
        end
        S_MEMREAD: AdrSrc = 1'b1;
        S_MEMWB: begin
          ResultSrc = 2'b01;
          if (rd_pc) PCWrite  = cond_ex;
          else       RegWrite = cond_ex;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = cond_ex;
        end
        S_EXECR: ALUControl = alu_dp;
        S_EXECI: begin
          ALUSrcB    = 2'b01;
          ALUControl = alu_dp;
        end
        S_ALUWB: begin
          if (!is_cmp) begin
            if (rd_pc) PCWrite  = cond_ex;
            else       RegWrite = cond_ex;
          end
        end
        S_BRANCH: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          PCWrite   = cond_ex;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
// Expected output vectors per cycle are queued by stimulus and popped by a monitor.
module tb_multicycle_controller;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
`ifdef MC_MEMREADY_EN
  logic        MemReady = 1'b1;
`endif
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

  multicycle_controller #(.STATE_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .Instr(Instr), .ALUFlags(ALUFlags),
`ifdef MC_MEMREADY_EN
    .MemReady(MemReady),
`endif
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
  );

  always #5 Clk = ~Clk;

  localparam logic [19:0] I_ADD   = 20'hE0821;  // ADD R1,R2,R3
  localparam logic [19:0] I_LDR   = 20'hE5901;  // LDR R1,[R0,#4]
  localparam logic [19:0] I_STR   = 20'hE5801;  // STR R1,[R0,#4]
  localparam logic [19:0] I_STRD  = 20'hE5001;  // STR R1,[R0,#-4]
  localparam logic [19:0] I_CMP   = 20'hE1500;  // CMP R0,R0
  localparam logic [19:0] I_BEQ   = 20'h0A000;  // BEQ
  localparam logic [19:0] I_ADDPC = 20'hE082F;  // ADD PC,R2,R3
  localparam logic [19:0] I_ORRS  = 20'hE1921;  // ORRS R1,R2,R3
  localparam logic [19:0] I_ADDEQ = 20'h02821;  // ADDEQ R1,R2,#4
  localparam logic [19:0] I_OP11  = 20'hEC000;  // op=11

  logic [19:0] exp_q[$];
  string       nm_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  event        smp_ev;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegSrc,ALUControl}
  function automatic logic [15:0] v(input logic pcw, adr, mw, irw, rw, input logic [1:0] rs,
                                    input logic asa, input logic [1:0] asb, imm, rsrc, alu);
    return {pcw, adr, mw, irw, rw, rs, asa, asb, imm, rsrc, alu};
  endfunction

  function automatic logic [15:0] fetch_v(input logic [1:0] imm, rsrc);
    return v(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, imm, rsrc, 2'b00);
  endfunction

  function automatic logic [15:0] decode_v(input logic [1:0] imm, rsrc);
    return v(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, imm, rsrc, 2'b00);
  endfunction

  always @(negedge Clk) -> smp_ev;

  initial begin : monitor
    logic [19:0] e, a;
    string nm;
    forever begin
      @(smp_ev);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        a  = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
              ImmSrc, RegSrc, ALUControl, dut.flags_q};
        n_vec++;
        if (a !== e) begin
          n_miss++;
          $display("FAIL %s: got outs=%h flags=%h, expected outs=%h flags=%h",
                   nm, a[19:4], a[3:0], e[19:4], e[3:0]);
        end
      end
    end
  end

  task automatic step(input logic [19:0] ins, input logic [3:0] af, input logic [15:0] e,
                      input logic [3:0] ef, input string nm);
    Instr    = ins;
    ALUFlags = af;
    exp_q.push_back({e, ef});
    nm_q.push_back(nm);
    @(posedge Clk);
    #1;
  endtask

  // Checks a cycle normally, then drops reset mid-cycle and checks the immediate effect.
  task automatic step_drop(input logic [19:0] ins, input logic [3:0] af, input logic [15:0] e,
                           input logic [3:0] ef, input string nm);
    Instr    = ins;
    ALUFlags = af;
    exp_q.push_back({e, ef});
    nm_q.push_back(nm);
    @(negedge Clk);
    #1;
    Rst = 1'b0;
    exp_q.push_back(20'h0);
    nm_q.push_back("reset drop immediate");
    #1;
    -> smp_ev;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst      = 1'b0;
    Instr    = I_LDR;
    ALUFlags = 4'hF;
    @(posedge Clk);
    #1;
    step(I_LDR, 4'hF, 16'h0, 4'h0, "reset cyc0");
    step(I_LDR, 4'hF, 16'h0, 4'h0, "reset cyc1");
    Rst = 1'b1;

    step(I_ADD, 4'hF, fetch_v(2'b00, 2'b00),  4'h0, "add fetch");
    step(I_ADD, 4'hF, decode_v(2'b00, 2'b00), 4'h0, "add decode");
    step(I_ADD, 4'hF, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00), 4'h0, "add execr");
    step(I_ADD, 4'hF, v(0,0,0,0,1,2'b00,0,2'b00,2'b00,2'b00,2'b00), 4'h0, "add aluwb");

    step(I_LDR, 4'h0, fetch_v(2'b01, 2'b00),  4'h0, "ldr fetch");
    step(I_LDR, 4'h0, decode_v(2'b01, 2'b00), 4'h0, "ldr decode");
    step(I_LDR, 4'h0, v(0,0,0,0,0,2'b00,0,2'b01,2'b01,2'b00,2'b00), 4'h0, "ldr memadr");
    step(I_LDR, 4'h0, v(0,1,0,0,0,2'b00,0,2'b00,2'b01,2'b00,2'b00), 4'h0, "ldr memread");
    step(I_LDR, 4'h0, v(0,0,0,0,1,2'b01,0,2'b00,2'b01,2'b00,2'b00), 4'h0, "ldr memwb");

    step(I_STR, 4'h0, fetch_v(2'b01, 2'b10),  4'h0, "str fetch");
    step(I_STR, 4'h0, decode_v(2'b01, 2'b10), 4'h0, "str decode");
    step(I_STR, 4'h0, v(0,0,0,0,0,2'b00,0,2'b01,2'b01,2'b10,2'b00), 4'h0, "str memadr");
    step(I_STR, 4'h0, v(0,1,1,0,0,2'b00,0,2'b00,2'b01,2'b10,2'b00), 4'h0, "str memwrite");

    step(I_CMP, 4'h4, fetch_v(2'b00, 2'b00),  4'h0, "cmp z fetch");
    step(I_CMP, 4'h4, decode_v(2'b00, 2'b00), 4'h0, "cmp z decode");
    step(I_CMP, 4'h4, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b01), 4'h0, "cmp z execr");
    step(I_CMP, 4'h4, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00), 4'h4, "cmp z aluwb");
    step(I_BEQ, 4'h0, fetch_v(2'b10, 2'b01),  4'h4, "beq taken fetch");
    step(I_BEQ, 4'h0, decode_v(2'b10, 2'b01), 4'h4, "beq taken decode");
    step(I_BEQ, 4'h0, v(1,0,0,0,0,2'b10,1,2'b01,2'b10,2'b01,2'b00), 4'h4, "beq taken branch");

    step(I_CMP, 4'h0, fetch_v(2'b00, 2'b00),  4'h4, "cmp nz fetch");
    step(I_CMP, 4'h0, decode_v(2'b00, 2'b00), 4'h4, "cmp nz decode");
    step(I_CMP, 4'h0, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b01), 4'h4, "cmp nz execr");
    step(I_CMP, 4'h0, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00), 4'h0, "cmp nz aluwb");
    step(I_BEQ, 4'h0, fetch_v(2'b10, 2'b01),  4'h0, "beq not fetch");
    step(I_BEQ, 4'h0, decode_v(2'b10, 2'b01), 4'h0, "beq not decode");
    step(I_BEQ, 4'h0, v(0,0,0,0,0,2'b10,1,2'b01,2'b10,2'b01,2'b00), 4'h0, "beq not branch");

    step(I_ADDPC, 4'h0, fetch_v(2'b00, 2'b00),  4'h0, "addpc fetch");
    step(I_ADDPC, 4'h0, decode_v(2'b00, 2'b00), 4'h0, "addpc decode");
    step(I_ADDPC, 4'h0, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00), 4'h0, "addpc execr");
    step(I_ADDPC, 4'h0, v(1,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00), 4'h0, "addpc aluwb");

    step(I_ORRS, 4'hB, fetch_v(2'b00, 2'b00),  4'h0, "orrs fetch");
    step(I_ORRS, 4'hB, decode_v(2'b00, 2'b00), 4'h0, "orrs decode");
    step(I_ORRS, 4'hB, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b11), 4'h0, "orrs execr");
    step(I_ORRS, 4'hB, v(0,0,0,0,1,2'b00,0,2'b00,2'b00,2'b00,2'b00), 4'h8, "orrs aluwb");

    step(I_ADDEQ, 4'hF, fetch_v(2'b00, 2'b00),  4'h8, "addeq fail fetch");
    step(I_ADDEQ, 4'hF, decode_v(2'b00, 2'b00), 4'h8, "addeq fail decode");
    step(I_ADDEQ, 4'hF, v(0,0,0,0,0,2'b00,0,2'b01,2'b00,2'b00,2'b00), 4'h8, "addeq fail execi");
    step(I_ADDEQ, 4'hF, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00), 4'h8, "addeq fail aluwb");

    step(I_OP11, 4'h0, fetch_v(2'b11, 2'b00),  4'h8, "op11 fetch");
    step(I_OP11, 4'h0, decode_v(2'b11, 2'b00), 4'h8, "op11 decode");

    step(I_CMP, 4'h6, fetch_v(2'b00, 2'b00),  4'h8, "cmp cv fetch");
    step(I_CMP, 4'h6, decode_v(2'b00, 2'b00), 4'h8, "cmp cv decode");
    step(I_CMP, 4'h6, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b01), 4'h8, "cmp cv execr");
    step(I_CMP, 4'h6, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00), 4'h6, "cmp cv aluwb");
    step(I_STRD, 4'h0, fetch_v(2'b01, 2'b10),  4'h6, "strd fetch");
    step(I_STRD, 4'h0, decode_v(2'b01, 2'b10), 4'h6, "strd decode");
    step(I_STRD, 4'h0, v(0,0,0,0,0,2'b00,0,2'b01,2'b01,2'b10,2'b01), 4'h6, "strd memadr sub");
    step_drop(I_STRD, 4'h0, v(0,1,1,0,0,2'b00,0,2'b00,2'b01,2'b10,2'b00), 4'h6, "strd memwrite");
    step(I_STRD, 4'h0, 16'h0, 4'h0, "held in reset");
    Rst = 1'b1;
    step(I_ADD, 4'h0, fetch_v(2'b00, 2'b00),  4'h0, "post-reset fetch");
    step(I_ADD, 4'h0, decode_v(2'b00, 2'b00), 4'h0, "post-reset decode");
    step(I_ADD, 4'h0, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00), 4'h0, "post-reset execr");
    step(I_ADD, 4'h0, v(0,0,0,0,1,2'b00,0,2'b00,2'b00,2'b00,2'b00), 4'h0, "post-reset aluwb");

`ifdef MC_MEMREADY_EN
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++)
      step(I_ADD, 4'h0, v(0,0,0,0,0,2'b10,1,2'b10,2'b00,2'b00,2'b00), 4'h0, "fetch wait");
    MemReady = 1'b1;
    step(I_ADD, 4'h0, fetch_v(2'b00, 2'b00),  4'h0, "fetch ready");
    step(I_ADD, 4'h0, decode_v(2'b00, 2'b00), 4'h0, "wait add decode");
    step(I_ADD, 4'h0, v(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00), 4'h0, "wait add execr");
    step(I_ADD, 4'h0, v(0,0,0,0,1,2'b00,0,2'b00,2'b00,2'b00,2'b00), 4'h0, "wait add aluwb");
    step(I_STR, 4'h0, fetch_v(2'b01, 2'b10),  4'h0, "wait str fetch");
    step(I_STR, 4'h0, decode_v(2'b01, 2'b10), 4'h0, "wait str decode");
    step(I_STR, 4'h0, v(0,0,0,0,0,2'b00,0,2'b01,2'b01,2'b10,2'b00), 4'h0, "wait str memadr");
    MemReady = 1'b0;
    for (int i = 0; i < 2; i++)
      step(I_STR, 4'h0, v(0,1,1,0,0,2'b00,0,2'b00,2'b01,2'b10,2'b00), 4'h0, "memwrite wait");
    MemReady = 1'b1;
    step(I_STR, 4'h0, v(0,1,1,0,0,2'b00,0,2'b00,2'b01,2'b10,2'b00), 4'h0, "memwrite ready");
    step(I_ADD, 4'h0, fetch_v(2'b00, 2'b00), 4'h0, "after memwrite fetch");
`endif

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge Clk);
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
